// File: rtl/mat_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mat_serializer
// Description : Reader end of the matrix-add datapath. Captures a complete
//               RSIZE x CSIZE matrix of DWIDTH-bit words in one handshake and
//               streams it out one element per beat with row/column tags and
//               a last flag. Supports zero-bubble back-to-back matrices.
// Options     : MATSER_TRANSPOSE_EN - stream in column-major order instead of
//               row-major; indices still report source positions.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_serializer #(
    parameter  int RSIZE  = 2,
    parameter  int CSIZE  = 3,
    parameter  int DWIDTH = 32,
    localparam int RW     = (RSIZE > 1) ? $clog2(RSIZE) : 1,
    localparam int CW     = (CSIZE > 1) ? $clog2(CSIZE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mat_valid,
    output logic              mat_ready,
    input  logic [DWIDTH-1:0] mat_in [RSIZE-1:0][CSIZE-1:0],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam logic [RW-1:0] c_ROW_MAX = RW'(RSIZE - 1);
    localparam logic [CW-1:0] c_COL_MAX = CW'(CSIZE - 1);

    state_t            state_q;
    logic [RW-1:0]     row_q;
    logic [RW-1:0]     row_d;
    logic [CW-1:0]     col_q;
    logic [CW-1:0]     col_d;
    logic [DWIDTH-1:0] buf_q [RSIZE-1:0][CSIZE-1:0];

    logic w_streaming;
    logic w_last;
    logic w_beat;
    logic w_capture;

    assign w_streaming = (state_q == S_STREAM);
    assign w_last      = w_streaming && (row_q == c_ROW_MAX) && (col_q == c_COL_MAX);
    assign w_beat      = w_streaming && out_ready;

    // A new matrix may enter when idle, or while the final beat of the
    // current matrix is being accepted (combinational from out_ready).
    assign mat_ready   = !w_streaming || (w_last && out_ready);
    assign w_capture   = mat_valid && mat_ready;

    // Data-side outputs read zero whenever no beat is presented.
    assign out_valid   = w_streaming;
    assign busy        = w_streaming;
    assign out_last    = w_last;
    assign out_data    = w_streaming ? buf_q[row_q][col_q] : '0;
    assign out_row     = w_streaming ? row_q : '0;
    assign out_col     = w_streaming ? col_q : '0;

    // Next element position for a non-last beat in the selected walk order.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
`ifdef MATSER_TRANSPOSE_EN
        if (row_q == c_ROW_MAX) begin
            row_d = '0;
            col_d = col_q + 1'b1;
        end else begin
            row_d = row_q + 1'b1;
        end
`else
        if (col_q == c_COL_MAX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end else begin
            col_d = col_q + 1'b1;
        end
`endif
    end

    // Control FSM: capture, walk the buffer, and return to idle or restart
    // on the last beat; nothing moves while a beat is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            for (int r = 0; r < RSIZE; r++) begin
                for (int c = 0; c < CSIZE; c++) begin
                    buf_q[r][c] <= '0;
                end
            end
        end else if (w_capture) begin
            buf_q   <= mat_in;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_STREAM;
        end else if (w_beat) begin
            if (w_last) begin
                state_q <= S_IDLE;
                row_q   <= '0;
                col_q   <= '0;
            end else begin
                row_q   <= row_d;
                col_q   <= col_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mat_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_serializer
// Description : Self-checking bench for mat_serializer. A queue of expected
//               beats is filled from each accepted matrix in stream order and
//               drained as beats are accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_serializer;

    localparam int R  = 2;
    localparam int C  = 3;
    localparam int DW = 32;
    localparam int RW = 1;
    localparam int CW = 2;
    localparam int N  = R * C;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          mat_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] mat_in [R-1:0][C-1:0];
    logic          mat_ready;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_d [$];
    int            exp_r [$];
    int            exp_c [$];
    bit            exp_l [$];

    always #5 clk = ~clk;

    mat_serializer #(.RSIZE(R), .CSIZE(C), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .mat_in    (mat_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy)
    );

    // mode 0: 10*i+j, mode 1: all 0xA5A5A5A5, otherwise random
    task automatic set_mat(input int mode);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mat_in[r][c] = (mode == 0) ? DW'(10 * r + c) :
                               (mode == 1) ? 32'hA5A5A5A5 : DW'($urandom);
    endtask

    // Append the currently presented matrix to the expected beat queue.
    task automatic load_expected();
        int k;
        k = 0;
`ifdef MATSER_TRANSPOSE_EN
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++) begin
`else
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
`endif
                exp_d.push_back(mat_in[r][c]);
                exp_r.push_back(r);
                exp_c.push_back(c);
                exp_l.push_back(k == N - 1);
                k++;
            end
    endtask

    task automatic pop_expected();
        void'(exp_d.pop_front());
        void'(exp_r.pop_front());
        void'(exp_c.pop_front());
        void'(exp_l.pop_front());
    endtask

    task automatic clear_expected();
        exp_d.delete(); exp_r.delete(); exp_c.delete(); exp_l.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mat_valid = 1'b0; out_ready = 1'b0; set_mat(2);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            out_data !== '0 || out_row !== '0 || out_col !== '0 || mat_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got v=%b l=%b b=%b d=%h r=%0d c=%0d mr=%b want all 0, mr=1",
                     out_valid, out_last, busy, out_data, out_row, out_col, mat_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        clear_expected();
        @(negedge clk);
        set_mat(0); mat_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (mat_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got mr=%b v=%b want mr=1 v=0", mat_ready, out_valid);
        end
        load_expected();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            mat_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp_d[0] ||
                out_row !== RW'(exp_r[0]) || out_col !== CW'(exp_c[0]) || out_last !== exp_l[0]) begin
                errors++;
                $display("FAIL basic_beat%0d got v=%b d=%h r=%0d c=%0d l=%b want v=1 d=%h r=%0d c=%0d l=%b",
                         k, out_valid, out_data, out_row, out_col, out_last,
                         exp_d[0], exp_r[0], exp_c[0], exp_l[0]);
            end
            pop_expected();
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || mat_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_end got v=%b b=%b mr=%b want v=0 b=0 mr=1", out_valid, busy, mat_ready);
        end
    endtask

    task automatic test_backpressure();
        int beats;
        int cyc;
        clear_expected();
        beats = 0;
        cyc   = 0;
        @(negedge clk);
        set_mat(2); mat_valid = 1'b1; out_ready = 1'b1;
        #1;
        load_expected();
        while (beats < N && cyc < 40) begin
            @(negedge clk);
            mat_valid = 1'b0;
            out_ready = (cyc % 3 == 0);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[0] || out_row !== RW'(exp_r[0]) ||
                out_col !== CW'(exp_c[0]) || out_last !== exp_l[0] ||
                mat_ready !== (exp_l[0] && out_ready)) begin
                errors++;
                $display("FAIL bp_cyc%0d got v=%b d=%h r=%0d c=%0d l=%b mr=%b want d=%h r=%0d c=%0d l=%b mr=%b",
                         cyc, out_valid, out_data, out_row, out_col, out_last, mat_ready,
                         exp_d[0], exp_r[0], exp_c[0], exp_l[0], exp_l[0] && out_ready);
            end
            if (out_ready) begin
                pop_expected();
                beats++;
            end
            cyc++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (beats != N || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got beats=%0d v=%b want beats=%0d v=0", beats, out_valid, N);
        end
    endtask

    task automatic test_back_to_back();
        clear_expected();
        @(negedge clk);
        set_mat(2); mat_valid = 1'b1; out_ready = 1'b1;
        #1;
        load_expected();
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            mat_valid = (k == N - 1);
            if (k == N - 1) set_mat(1);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[0] || out_row !== RW'(exp_r[0]) ||
                out_col !== CW'(exp_c[0]) || out_last !== exp_l[0] || mat_ready !== exp_l[0]) begin
                errors++;
                $display("FAIL b2b_beat%0d got v=%b d=%h r=%0d c=%0d l=%b mr=%b want d=%h r=%0d c=%0d l=%b mr=%b",
                         k, out_valid, out_data, out_row, out_col, out_last, mat_ready,
                         exp_d[0], exp_r[0], exp_c[0], exp_l[0], exp_l[0]);
            end
            pop_expected();
            if (k == N - 1) load_expected();
        end
        @(negedge clk);
        mat_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mat_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end got v=%b mr=%b want v=0 mr=1", out_valid, mat_ready);
        end
    endtask

    task automatic test_ignore_midstream();
        clear_expected();
        @(negedge clk);
        set_mat(2); mat_valid = 1'b1; out_ready = 1'b1;
        #1;
        load_expected();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            mat_valid = (k == 2);
            if (k == 2) set_mat(2);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[0] || out_row !== RW'(exp_r[0]) ||
                out_col !== CW'(exp_c[0]) || out_last !== exp_l[0] || mat_ready !== exp_l[0]) begin
                errors++;
                $display("FAIL ignore_beat%0d got d=%h r=%0d c=%0d l=%b mr=%b want d=%h r=%0d c=%0d l=%b mr=%b",
                         k, out_data, out_row, out_col, out_last, mat_ready,
                         exp_d[0], exp_r[0], exp_c[0], exp_l[0], exp_l[0]);
            end
            pop_expected();
        end
        @(negedge clk);
        mat_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_end got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        clear_expected();
        @(negedge clk);
        set_mat(2); mat_valid = 1'b1; out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        mat_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || out_row !== '0 || out_col !== '0) begin
            errors++;
            $display("FAIL areset_drop got v=%b b=%b l=%b d=%h r=%0d c=%0d want all 0",
                     out_valid, busy, out_last, out_data, out_row, out_col);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_mat(2); mat_valid = 1'b1;
        #1;
        checks++;
        if (mat_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle got mr=%b v=%b want mr=1 v=0", mat_ready, out_valid);
        end
        load_expected();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            mat_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[0] || out_row !== RW'(exp_r[0]) ||
                out_col !== CW'(exp_c[0]) || out_last !== exp_l[0]) begin
                errors++;
                $display("FAIL areset_beat%0d got v=%b d=%h r=%0d c=%0d l=%b want d=%h r=%0d c=%0d l=%b",
                         k, out_valid, out_data, out_row, out_col, out_last,
                         exp_d[0], exp_r[0], exp_c[0], exp_l[0]);
            end
            pop_expected();
        end
    endtask

    task automatic test_random();
        bit exp_v;
        bit exp_mr;
        clear_expected();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            mat_valid = ($urandom_range(0, 3) == 0);
            if (mat_valid) set_mat(2);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_v  = (exp_d.size() != 0);
            exp_mr = !exp_v || (exp_l[0] && out_ready);
            checks++;
            if (out_valid !== exp_v || mat_ready !== exp_mr ||
                (exp_v && (out_data !== exp_d[0] || out_row !== RW'(exp_r[0]) ||
                           out_col !== CW'(exp_c[0]) || out_last !== exp_l[0]))) begin
                errors++;
                $display("FAIL rand_cyc%0d got v=%b mr=%b d=%h r=%0d c=%0d l=%b want v=%b mr=%b d=%h r=%0d c=%0d l=%b",
                         cyc, out_valid, mat_ready, out_data, out_row, out_col, out_last,
                         exp_v, exp_mr, exp_v ? exp_d[0] : '0, exp_v ? exp_r[0] : 0,
                         exp_v ? exp_c[0] : 0, exp_v ? exp_l[0] : 1'b0);
            end
            if (exp_v && out_ready) pop_expected();
            if (mat_valid && exp_mr) load_expected();
        end
        @(negedge clk);
        mat_valid = 1'b0;
        out_ready = 1'b1;
        repeat (N + 1) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || mat_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_drain got v=%b mr=%b want v=0 mr=1", out_valid, mat_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_ignore_midstream();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mat_serializer.md
Name: mat_serializer

Overview:
- Reader end of the matrix-add datapath: captures a full rsize x csize matrix of dwidth-bit words in one cycle via a valid/ready handshake.
- Streams the captured matrix out one element per beat over a valid/ready stream, tagged with row/column indices and a last flag.
- Sits downstream of the element-wise matrix adder and turns its parallel result array into a narrow stream for memory or bus write-back.

Parameters:
rsize, 2, number of matrix rows (>=1)
csize, 3, number of matrix columns (>=1)
dwidth, 32, element width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mat_valid  input  1  mat_in holds a valid matrix
mat_ready  output  1  block can accept a matrix this cycle
mat_in  input  [dwidth-1:0] x [rsize-1:0][csize-1:0]  unpacked matrix, same array shape as the adder result
out_valid  output  1  out_data/out_row/out_col/out_last valid
out_ready  input  1  downstream accepts current beat
out_data  output  dwidth  current element
out_row  output  RW=max(1,$clog2(rsize))  row index of out_data
out_col  output  CW=max(1,$clog2(csize))  column index of out_data
out_last  output  1  current beat is the final element of the matrix
busy  output  1  high while in STREAM

Behaviour:
- Reset (rst_n low, asynchronous):
  - State=IDLE; buffer cleared to 0.
  - Row/col counters = 0.
  - out_valid=0, out_last=0, busy=0; out_data, out_row, out_col all read 0.
  - Reset mid-stream abandons the matrix. No further beats follow, and the first cycle after release is IDLE with mat_ready=1.
- States:
  - IDLE: mat_ready=1, out_valid=0.
    - mat_valid=1 captures all of mat_in into the buffer, clears counters, and moves to STREAM.
  - STREAM: out_valid=1, busy=1.
    - out_data = buffer[row][col], out_row=row, out_col=col.
    - out_last = (row==rsize-1 && col==csize-1).
- Beat accept = out_valid && out_ready.
  - Non-last beat: col increments; at col==csize-1, col wraps to 0 and row increments.
  - Last beat: if mat_valid=1 in the same cycle, the new matrix is captured, counters clear, and the block stays in STREAM (zero-bubble back-to-back). Otherwise the block goes to IDLE.
- mat_ready = (state==IDLE) || (state==STREAM && out_last && out_ready). This is a combinational path from out_ready.
- Outputs are stable while out_valid && !out_ready: no index change and no buffer write. mat_valid is ignored whenever mat_ready=0.
- Latency: matrix handshake at cycle N gives element (0,0) on the output at N+1. With out_ready held at 1, a matrix takes exactly rsize*csize beats.
- rsize*csize==1: every beat has out_last=1; rsize==1 or csize==1 reduces to a single row or column walk.
- Counters never exceed rsize-1 / csize-1, and there are no index values outside the valid range.

Optional Feature:
- Macro: MATSER_TRANSPOSE_EN.
- Defined:
  - Stream order is column-major: row increments first, wrapping to 0 at rsize-1 with col incrementing.
  - out_row/out_col still report source indices.
  - out_last is still asserted on (rsize-1, csize-1), which is also the last element in this order.
- Undefined: row-major order as described in Behaviour.

Test Plan:
- Reset, then hold mat_valid=1 with element [i][j]=10*i+j and out_ready=1 (rsize=2, csize=3). Required response:
  - Beats 0,1,2,10,11,12 on consecutive cycles starting the cycle after capture.
  - (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - out_last only on 12; then IDLE with mat_ready=1.
- Backpressure: toggle out_ready 1,0,0,1,... during stream -> out_data/out_row/out_col/out_last held while out_ready=0; sequence and beat count (6) unchanged, no duplicates or drops.
- Back-to-back: second matrix (all 0xA5A5A5A5) presented with mat_valid=1 during last beat of first, out_ready=1. Required response:
  - mat_ready=1 on that cycle only.
  - Next cycle out_data=0xA5A5A5A5 at (0,0) with no bubble; total 12 beats in 12 consecutive cycles.
- mat_valid pulsed with a different value during beat 2 (not last) -> ignored; streamed values remain from the first matrix.
- Reset asserted asynchronously after beat 3 accepted -> out_valid drops immediately; after release, mat_ready=1 and a new matrix streams from (0,0).
- With MATSER_TRANSPOSE_EN, same matrix as the first test -> beats 0,10,1,11,2,12 with (row,col) (0,0),(1,0),(0,1),(1,1),(0,2),(1,2); out_last on 12 only.
